// File: rtl/mem_stage_ctrl_pkg.sv
// Shared processor definitions for the memory stage: opcodes, FSM encoding and decode helpers.
package mem_stage_ctrl_pkg;

  localparam logic [4:0] OpAlu  = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpSw   = 5'b00111;
  localparam logic [4:0] OpLw   = 5'b01000;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_e;

  function automatic logic is_mem_op(logic [4:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

  function automatic logic writes_reg(logic [4:0] op);
    return (op == OpLw) || (op == OpAlu) || (op == OpAddi);
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// IDLE/ACCESS sequencer for data-memory requests; owns the rden/wren strobes.
module mem_req_fsm
  import mem_stage_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic is_load,
  input  logic ack,
  output logic ready,
  output logic rden,
  output logic wren,
  output logic done
);

  mem_state_e state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StAccess;
      StAccess: if (ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Only lw/sw ever reach ACCESS, so a non-load is a store.
  always_comb begin
    ready = 1'b0;
    rden  = 1'b0;
    wren  = 1'b0;
    done  = 1'b0;
    case (state_q)
      StIdle: ready = 1'b1;
      StAccess: begin
        rden = is_load;
        wren = ~is_load;
        done = ack;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage: X/M acceptance, M register, W-to-M store bypass and M/W register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        xm_valid,
  input  logic [4:0]  xm_opcode,
  input  logic [4:0]  xm_rd,
  input  logic [31:0] xm_alu,
  input  logic [31:0] xm_b,
  output logic        xm_ready,
  output logic [11:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_wren,
  output logic        dmem_rden,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mw_valid,
  output logic [4:0]  mw_opcode,
  output logic [4:0]  mw_rd,
  output logic [31:0] mw_data,
  output logic        mw_we
);

  logic [4:0]  m_opcode_q;
  logic [4:0]  m_rd_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;

  logic        mw_valid_q;
  logic [4:0]  mw_opcode_q;
  logic [4:0]  mw_rd_q;
  logic [31:0] mw_data_q;

  logic        accept;
  logic        xm_is_mem;
  logic        start;
  logic        done;
  logic        m_is_load;
  logic        bypass;
  logic [31:0] store_data;

  assign accept    = xm_valid & xm_ready;
  assign xm_is_mem = is_mem_op(xm_opcode);
  assign start     = accept & xm_is_mem;
  assign m_is_load = (m_opcode_q == OpLw);

  // A load sitting in M/W this cycle supplies the store data it would otherwise miss.
  assign bypass = mw_valid_q && (mw_opcode_q == OpLw) && (mw_rd_q == xm_rd) && (xm_rd != 5'd0);
  assign store_data = bypass ? mw_data_q : xm_b;

  mem_req_fsm u_mem_req_fsm (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .is_load (m_is_load),
    .ack     (dmem_ack),
    .ready   (xm_ready),
    .rden    (dmem_rden),
    .wren    (dmem_wren),
    .done    (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      m_opcode_q <= 5'd0;
      m_rd_q     <= 5'd0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
    end else if (start) begin
      m_opcode_q <= xm_opcode;
      m_rd_q     <= xm_rd;
      m_addr_q   <= xm_alu;
      m_wdata_q  <= store_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mw_valid_q  <= 1'b0;
      mw_opcode_q <= 5'd0;
      mw_rd_q     <= 5'd0;
      mw_data_q   <= 32'd0;
    end else if (done) begin
      mw_valid_q  <= 1'b1;
      mw_opcode_q <= m_opcode_q;
      mw_rd_q     <= m_rd_q;
      mw_data_q   <= m_is_load ? dmem_rdata : m_addr_q;
    end else if (accept && !xm_is_mem) begin
      mw_valid_q  <= 1'b1;
      mw_opcode_q <= xm_opcode;
      mw_rd_q     <= xm_rd;
      mw_data_q   <= xm_alu;
    end else begin
      mw_valid_q  <= 1'b0;
    end
  end

  assign dmem_addr  = m_addr_q[11:0];
  assign dmem_wdata = m_wdata_q;

  assign mw_valid  = mw_valid_q;
  assign mw_opcode = mw_opcode_q;
  assign mw_rd     = mw_rd_q;
  assign mw_data   = mw_data_q;
  assign mw_we     = mw_valid_q & writes_reg(mw_opcode_q) & (mw_rd_q != 5'd0);

endmodule
